q_hist_bank: RTL and testbench

Parametrised Q-format history register bank that generalises the single Q31 load register into DEPTH entries with indexed load, shift-in, sequential clear and optional input saturation. It holds filter memories for the pre-processor and LPC stages, such as the x[n-1], x[n-2], y[n-1] and y[n-2] taps of the high-pass filter. Wider accumulator results can be written directly and are narrowed to WIDTH on entry.

---
 rtl/q_fmt_pkg.sv | 30 +++
 rtl/q_sat_narrow.sv | 34 +++
 rtl/q_hist_bank.sv | 145 ++++++++++++++
 tb/tb_q_hist_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/q_fmt_pkg.sv
// rtl/q_fmt_pkg.sv - shared Q-format constants, history-bank states and saturating narrow
package q_fmt_pkg;

    localparam logic [31:0] Q31_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] Q31_MIN  = 32'h8000_0000;
    localparam int          Q_CALC_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } hist_state_t;

    // Clamp a sign-extended value into the signed range of 'width' bits; result stays sign-extended.
    function automatic logic signed [Q_CALC_W-1:0] sat_narrow(
        input logic signed [Q_CALC_W-1:0] d,
        input int unsigned                width
    );
        logic signed [Q_CALC_W-1:0] hi;
        logic signed [Q_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (d > hi) begin
            return hi;
        end else if (d < lo) begin
            return lo;
        end
        return d;
    endfunction

endpackage

// File: rtl/q_sat_narrow.sv
// rtl/q_sat_narrow.sv - IN_WIDTH to WIDTH narrower, saturating when Q_HIST_SAT_EN is defined
module q_sat_narrow
    import q_fmt_pkg::*;
#(
    parameter int IN_WIDTH = 40,
    parameter int WIDTH    = 32
) (
    input  logic [IN_WIDTH-1:0] din,
    output logic [WIDTH-1:0]    dout,
    output logic                sat
);

`ifdef Q_HIST_SAT_EN
    logic signed [Q_CALC_W-1:0] dx;
    logic signed [Q_CALC_W-1:0] dn;

    assign dx   = Q_CALC_W'($signed(din));
    assign dn   = sat_narrow(dx, WIDTH);
    assign dout = dn[WIDTH-1:0];
    // Any difference between clamped and original value means the clamp engaged.
    assign sat  = (dn != dx);
`else
    assign dout = din[WIDTH-1:0];
    assign sat  = 1'b0;

    generate
        if (IN_WIDTH > WIDTH) begin : g_drop
            logic unused_hi;
            assign unused_hi = ^din[IN_WIDTH-1:WIDTH];
        end
    endgenerate
`endif

endmodule

// File: rtl/q_hist_bank.sv
// rtl/q_hist_bank.sv - Q-format history bank: indexed load, shift-in, sequential clear; Q_HIST_SAT_EN enables saturation
module q_hist_bank
    import q_fmt_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 4,
    parameter  int IN_WIDTH = 40,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   mclk,
    input  logic                   reset,
    input  logic                   ld,
    input  logic                   shift,
    input  logic                   clr,
    input  logic [AW-1:0]          addr,
    input  logic [IN_WIDTH-1:0]    d,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       q,
    output logic [DEPTH*WIDTH-1:0] q_all,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] tap [DEPTH];
    hist_state_t      state;
    hist_state_t      state_nxt;
    logic [AW-1:0]    cnt;
    logic [WIDTH-1:0] nd;
    logic             nsat;
    logic             do_shift;
    logic             do_ld;
    logic             last_step;

    q_sat_narrow #(
        .IN_WIDTH (IN_WIDTH),
        .WIDTH    (WIDTH)
    ) u_narrow (
        .din  (d),
        .dout (nd),
        .sat  (nsat)
    );

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_shift  = 1'b0;
        do_ld     = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                end else if (shift) begin
                    do_shift = 1'b1;
                end else if (ld && ({1'b0, addr} < DEPTH_L)) begin
                    do_ld = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    last_step = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= last_step;
            if (state == CLEAR && !last_step) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap[i] <= '0;
            end
        end else if (state == CLEAR) begin
            tap[cnt] <= '0;
        end else if (do_shift) begin
            tap[0] <= nd;
            for (int i = 1; i < DEPTH; i++) begin
                tap[i] <= tap[i-1];
            end
        end else if (do_ld) begin
            tap[addr] <= nd;
        end
    end

`ifdef Q_HIST_SAT_EN
    // A saturating write in the same cycle as ovf_clr keeps the flag set.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if ((do_shift || do_ld) && nsat) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = nsat ^ ovf_clr;
    assign ovf        = 1'b0;
`endif

    assign busy = (state == CLEAR);

    always_comb begin
        q = '0;
        if ({1'b0, rd_addr} < DEPTH_L) begin
            q = tap[rd_addr];
        end
    end

    always_comb begin
        q_all = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_all[i*WIDTH +: WIDTH] = tap[i];
        end
    end

endmodule

// File: tb/tb_q_hist_bank.sv
// tb/tb_q_hist_bank.sv - self-checking bench for q_hist_bank (DEPTH=4 vector table, DEPTH=3 sequences)
module tb_q_hist_bank;
    import q_fmt_pkg::*;

`ifdef Q_HIST_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         mclk;
    logic         reset;
    logic         ld, shift, clr, ovf_clr;
    logic [1:0]   addr, rd_addr;
    logic [39:0]  d;
    logic [31:0]  q;
    logic [127:0] q_all;
    logic         busy, done, ovf;

    logic         ld3, shift3, clr3, ovf_clr3;
    logic [1:0]   addr3, rd_addr3;
    logic [39:0]  d3;
    logic [31:0]  q3;
    logic [95:0]  q_all3;
    logic         busy3, done3, ovf3;

    int errors = 0;
    int checks = 0;

    q_hist_bank #(.WIDTH(32), .DEPTH(4), .IN_WIDTH(40)) dut (
        .mclk(mclk), .reset(reset), .ld(ld), .shift(shift), .clr(clr),
        .addr(addr), .d(d), .rd_addr(rd_addr), .q(q), .q_all(q_all),
        .busy(busy), .done(done), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    q_hist_bank #(.WIDTH(32), .DEPTH(3), .IN_WIDTH(40)) dut3 (
        .mclk(mclk), .reset(reset), .ld(ld3), .shift(shift3), .clr(clr3),
        .addr(addr3), .d(d3), .rd_addr(rd_addr3), .q(q3), .q_all(q_all3),
        .busy(busy3), .done(done3), .ovf(ovf3), .ovf_clr(ovf_clr3)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct {
        string        name;
        logic         ld, sh, cl, oc;
        logic [1:0]   a;
        logic [39:0]  d;
        logic [1:0]   rd;
        logic [127:0] e_all;
        logic [31:0]  e_q;
        logic         e_busy, e_done, e_ovf;
    } vec_t;

    vec_t vecs [21];
    vec_t sb [$];
    vec_t e;

    function automatic vec_t mk(input string n, input logic l, input logic s, input logic c,
                                input logic o, input logic [1:0] a, input logic [39:0] dd,
                                input logic [1:0] r, input logic [31:0] t3, input logic [31:0] t2,
                                input logic [31:0] t1, input logic [31:0] t0,
                                input logic b, input logic dn, input logic ov);
        vec_t v;
        v.name = n; v.ld = l; v.sh = s; v.cl = c; v.oc = o; v.a = a; v.d = dd; v.rd = r;
        v.e_all = {t3, t2, t1, t0};
        case (r)
            2'd0: v.e_q = t0;
            2'd1: v.e_q = t1;
            2'd2: v.e_q = t2;
            default: v.e_q = t3;
        endcase
        v.e_busy = b; v.e_done = dn; v.e_ovf = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc3(input logic l, input logic s, input logic c, input logic [1:0] a,
                        input logic [39:0] dd, input logic [1:0] r);
        @(negedge mclk);
        ld3 = l; shift3 = s; clr3 = c; addr3 = a; d3 = dd; rd_addr3 = r;
        @(posedge mclk);
        #1;
    endtask

    logic [31:0] x, a0, a1, a3, b;

    initial begin
        reset = 1'b0;
        ld = 0; shift = 0; clr = 0; ovf_clr = 0; addr = 0; d = 0; rd_addr = 0;
        ld3 = 0; shift3 = 0; clr3 = 0; ovf_clr3 = 0; addr3 = 0; d3 = 0; rd_addr3 = 0;

        x  = 32'h1234_5678;
        a1 = SAT ? Q31_MAX : 32'h2345_6789;
        a3 = SAT ? Q31_MAX : 32'h8000_0000;
        a0 = SAT ? Q31_MIN : 32'h7FFF_FFFF;
        b  = SAT ? Q31_MIN : 32'h0000_0000;

        vecs[0]  = mk("sh1",       0,1,0,0, 2'd0, 40'd1,           2'd0, 0,0,0,1,                   0,0,0);
        vecs[1]  = mk("sh2",       0,1,0,0, 2'd0, 40'd2,           2'd1, 0,0,1,2,                   0,0,0);
        vecs[2]  = mk("sh3",       0,1,0,0, 2'd0, 40'd3,           2'd2, 0,1,2,3,                   0,0,0);
        vecs[3]  = mk("sh4",       0,1,0,0, 2'd0, 40'd4,           2'd3, 1,2,3,4,                   0,0,0);
        vecs[4]  = mk("ld_sh",     1,1,0,0, 2'd2, 40'h12345678,    2'd0, 2,3,4,x,                   0,0,0);
        vecs[5]  = mk("ld2",       1,0,0,0, 2'd2, 40'h12345678,    2'd2, 2,x,4,x,                   0,0,0);
        vecs[6]  = mk("clr_k",     1,1,1,0, 2'd0, 40'h99,          2'd1, 2,x,4,x,                   1,0,0);
        vecs[7]  = mk("clr_k1",    1,1,0,0, 2'd3, 40'd7,           2'd0, 2,x,4,0,                   1,0,0);
        vecs[8]  = mk("clr_k2",    1,0,0,0, 2'd1, 40'd9,           2'd1, 2,x,0,0,                   1,0,0);
        vecs[9]  = mk("clr_k3",    0,0,1,0, 2'd0, 40'd0,           2'd2, 2,0,0,0,                   1,0,0);
        vecs[10] = mk("clr_k4",    0,1,0,0, 2'd0, 40'd5,           2'd3, 0,0,0,0,                   0,1,0);
        vecs[11] = mk("post_clr",  1,0,0,0, 2'd3, 40'h33,          2'd3, 32'h33,0,0,0,              0,0,0);
        vecs[12] = mk("narrow_hi", 1,0,0,0, 2'd1, 40'h01_2345_6789,2'd1, 32'h33,0,a1,0,             0,0,SAT);
        vecs[13] = mk("pos_sat",   1,0,0,0, 2'd3, 40'h00_8000_0000,2'd3, a3,0,a1,0,                 0,0,SAT);
        vecs[14] = mk("neg_sat",   1,0,0,1, 2'd0, 40'hFF_7FFF_FFFF,2'd0, a3,0,a1,a0,                0,0,SAT);
        vecs[15] = mk("ovf_clr",   1,0,0,1, 2'd2, 40'hFF_FFFF_FFFB,2'd2, a3,32'hFFFF_FFFB,a1,a0,    0,0,0);
        vecs[16] = mk("sh_max",    0,1,0,0, 2'd0, 40'h00_7FFF_FFFF,2'd0, 32'hFFFF_FFFB,a1,a0,32'h7FFF_FFFF, 0,0,0);
        vecs[17] = mk("sh_min",    0,1,0,0, 2'd0, 40'hFF_8000_0000,2'd1, a1,a0,32'h7FFF_FFFF,32'h8000_0000, 0,0,0);
        vecs[18] = mk("sh_negsat", 0,1,0,0, 2'd0, 40'h80_0000_0000,2'd0, a0,32'h7FFF_FFFF,32'h8000_0000,b, 0,0,SAT);
        vecs[19] = mk("ovf_hold",  0,0,0,0, 2'd0, 40'd0,           2'd3, a0,32'h7FFF_FFFF,32'h8000_0000,b, 0,0,SAT);
        vecs[20] = mk("ovf_drop",  0,0,0,1, 2'd0, 40'd0,           2'd2, a0,32'h7FFF_FFFF,32'h8000_0000,b, 0,0,0);

        // Reset held with commands pending must leave the bank clear.
        shift = 1; d = 40'h77;
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_q_all", q_all, '0);
        chk("rst_q", {96'd0, q}, '0);
        chk("rst_busy", {127'd0, busy}, '0);
        chk("rst_done", {127'd0, done}, '0);
        chk("rst_ovf", {127'd0, ovf}, '0);
        @(negedge mclk);
        shift = 0; reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge mclk);
            ld = vecs[i].ld; shift = vecs[i].sh; clr = vecs[i].cl; ovf_clr = vecs[i].oc;
            addr = vecs[i].a; d = vecs[i].d; rd_addr = vecs[i].rd;
            sb.push_back(vecs[i]);
            @(posedge mclk);
            #1;
            e = sb.pop_front();
            chk({e.name, "_q_all"}, q_all, e.e_all);
            chk({e.name, "_q"}, {96'd0, q}, {96'd0, e.e_q});
            chk({e.name, "_busy"}, {127'd0, busy}, {127'd0, e.e_busy});
            chk({e.name, "_done"}, {127'd0, done}, {127'd0, e.e_done});
            chk({e.name, "_ovf"}, {127'd0, ovf}, {127'd0, e.e_ovf});
        end
        @(negedge mclk);
        ld = 0; shift = 0; clr = 0; ovf_clr = 0;

        // DEPTH=3: out-of-range write and read.
        cyc3(1, 0, 0, 2'd1, 40'h11, 2'd1);
        chk("d3_ld1", {32'd0, q_all3}, {32'd0, 32'h0, 32'h11, 32'h0});
        cyc3(1, 0, 0, 2'd3, 40'h00_8000_0000, 2'd3);
        chk("d3_ld3_nowr", {32'd0, q_all3}, {32'd0, 32'h0, 32'h11, 32'h0});
        chk("d3_rd3", {96'd0, q3}, '0);
        chk("d3_ovf", {127'd0, ovf3}, '0);
        cyc3(1, 0, 0, 2'd0, 40'h22, 2'd1);
        chk("d3_rd1", {96'd0, q3}, {96'd0, 32'h11});
        cyc3(1, 0, 0, 2'd2, 40'h44, 2'd2);
        chk("d3_fill", {32'd0, q_all3}, {32'd0, 32'h44, 32'h11, 32'h22});

        // DEPTH=3 full clear.
        cyc3(0, 0, 1, 2'd0, 40'd0, 2'd2);
        chk("d3_clr_busy", {127'd0, busy3}, 128'd1);
        chk("d3_clr_k", {32'd0, q_all3}, {32'd0, 32'h44, 32'h11, 32'h22});
        cyc3(0, 1, 0, 2'd0, 40'h9, 2'd2);
        chk("d3_clr_k1", {32'd0, q_all3}, {32'd0, 32'h44, 32'h11, 32'h0});
        chk("d3_clr_k1_busy", {127'd0, busy3}, 128'd1);
        cyc3(1, 0, 0, 2'd0, 40'h9, 2'd2);
        chk("d3_clr_k2", {32'd0, q_all3}, {32'd0, 32'h44, 32'h0, 32'h0});
        chk("d3_clr_k2_done", {127'd0, done3}, '0);
        cyc3(0, 0, 0, 2'd0, 40'd0, 2'd2);
        chk("d3_clr_k3", {32'd0, q_all3}, '0);
        chk("d3_clr_k3_busy", {127'd0, busy3}, '0);
        chk("d3_clr_k3_done", {127'd0, done3}, 128'd1);
        cyc3(0, 0, 0, 2'd0, 40'd0, 2'd2);
        chk("d3_done_once", {127'd0, done3}, '0);

        // Reset during the second clear cycle aborts without a done pulse.
        cyc3(1, 0, 0, 2'd2, 40'h55, 2'd2);
        cyc3(0, 0, 1, 2'd0, 40'd0, 2'd2);
        cyc3(0, 0, 0, 2'd0, 40'd0, 2'd2);
        chk("d3_abort_pre_busy", {127'd0, busy3}, 128'd1);
        @(negedge mclk);
        reset = 1'b0;
        #1;
        chk("d3_abort_busy", {127'd0, busy3}, '0);
        chk("d3_abort_taps", {32'd0, q_all3}, '0);
        chk("d3_abort_done", {127'd0, done3}, '0);
        chk("d4_midrst_taps", q_all, '0);
        chk("d4_midrst_ovf", {127'd0, ovf}, '0);
        @(posedge mclk);
        @(negedge mclk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc3(0, 0, 0, 2'd0, 40'd0, 2'd2);
            chk("d3_post_abort_done", {127'd0, done3}, '0);
            chk("d3_post_abort_busy", {127'd0, busy3}, '0);
        end
        chk("d4_post_rst_busy", {127'd0, busy}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
